readout_fsm: RTL and testbench
==============================

// Module: readout_fsm
// PURPOSE
//  Downstream of the pixel de-accumulation stage. Once the frame RAM holds the
//  final per-pixel values, this block scans it row-major and streams each 12-bit
//  pixel as two bytes over a valid/ready byte interface to the serial TX.
//  Single clock domain. Owns its own row/col counters and drives the RAM read port.
// PARAMETERS
//  PIXEL_N_COLS  24  pixels per row
//  PIXEL_N_ROWS  24  rows per frame
//  NB_ADC        12  pixel width in bits; legal range 9..16
//  NB_MEM_ADDR   10  RAM address width; must satisfy 2^NB_MEM_ADDR >= COLS*ROWS
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous, active-high reset
//  i_start      in   1            start one frame readout; sampled only in IDLE
//  o_busy       out  1            high in every state except IDLE
//  o_done       out  1            one-cycle pulse after the last byte is accepted
//  o_ram_addr   out  NB_MEM_ADDR  read address = row*PIXEL_N_COLS + col
//  o_ram_read   out  1            read strobe; high only in RD_ADDR
//  i_ram_value  in   NB_ADC       RAM read data; valid 1 cycle after o_ram_read
//  o_tx_data    out  8            byte to transmit
//  o_tx_valid   out  1            byte on o_tx_data is valid
//  i_tx_ready   in   1            sink accepts the byte when valid&&ready at the clk edge
// BEHAVIOUR
//  Reset values: state=IDLE, row=col=0, pix_reg=0. Outputs: o_busy=0, o_done=0,
//   o_ram_read=0, o_tx_valid=0, o_ram_addr=0, o_tx_data=0.
//  States:
//   IDLE     i_start -> RD_ADDR (or HDR_0 when the macro is defined); else stay.
//   RD_ADDR  o_ram_read=1 and o_ram_addr=row*COLS+col -> RD_WAIT.
//   RD_WAIT  pix_reg <= i_ram_value -> SEND_HI.
//   SEND_HI  o_tx_valid=1, o_tx_data={(16-NB_ADC) zeros, pix_reg[NB_ADC-1:8]}.
//            On ready -> SEND_LO; otherwise hold.
//   SEND_LO  o_tx_valid=1, o_tx_data=pix_reg[7:0]. On ready:
//            - col == COLS-1: col <= 0 and row increments.
//            - otherwise col increments.
//            - next state is DONE if row==ROWS-1 && col==COLS-1, else RD_ADDR.
//   DONE     o_done=1 for one cycle; row and col cleared -> IDLE.
//  Latency: i_start sampled at edge k. RD_ADDR runs in cycle k+1. First o_tx_valid in cycle k+3.
//  Per pixel, with the sink always ready: 4 cycles (RD_ADDR, RD_WAIT, SEND_HI, SEND_LO).
//  Handshake rules:
//   - o_tx_data is stable while o_tx_valid && !i_tx_ready.
//   - o_tx_valid never drops without a transfer.
//   - o_tx_valid does not depend combinationally on i_tx_ready.
//  i_start while busy: ignored; it is not queued.
//  Reset mid-frame (any state): next cycle is IDLE with all outputs at reset values.
//   The partial frame is abandoned. No o_done.
//  Frame total: 2*COLS*ROWS bytes, i.e. 1152 bytes at the defaults.
//  The RAM is read only. This block never writes it.
// CONFIGURATION
//  READOUT_HEADER_EN
//   Defined: IDLE -> HDR_0 (o_tx_data=8'hA5) -> HDR_1 (8'h5A) -> RD_ADDR.
//    Each header state follows the same valid/ready hold rules as pixel bytes.
//    Frame becomes 1154 bytes. First valid is in cycle k+1.
//   Undefined: the header states do not exist and the frame is pixel bytes only.
// TESTING
//  1 Reset check: hold rst 3 cycles -> all outputs 0 and o_busy=0.
//  2 Full frame: RAM[a]=a&12'hFFF, i_tx_ready=1, pulse i_start.
//    -> Byte stream 00,00,00,01,...,02,3F (last pixel a=575).
//    -> 1152 bytes total. o_done pulses exactly once.
//  3 Backpressure: toggle i_tx_ready randomly (~50%).
//    -> Same byte sequence as scenario 2.
//    -> o_tx_data stable whenever o_tx_valid && !i_tx_ready.
//  4 Ignored start: pulse i_start repeatedly during readout.
//    -> Exactly one frame is sent. A new i_start after o_done starts a second identical frame.
//  5 Mid-frame reset: assert rst after byte 100.
//    -> Next cycle o_tx_valid=0, o_busy=0, no o_done.
//    -> Next i_start restarts at address 0.
//  6 Header: with READOUT_HEADER_EN, scenario 2 yields A5,5A,00,00,00,01,... and 1154 bytes.

Source files
------------

// File: rtl/readout_fsm.sv
// readout_fsm: scans the frame RAM row-major and streams each pixel as two
// bytes (high byte first) over a valid/ready byte interface.
// Optional build macro READOUT_HEADER_EN prepends the header bytes A5,5A
// to every frame; when undefined the frame is pixel bytes only.
module readout_fsm #(
  parameter int PIXEL_N_COLS = 24,
  parameter int PIXEL_N_ROWS = 24,
  parameter int NB_ADC       = 12,
  parameter int NB_MEM_ADDR  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NB_MEM_ADDR-1:0] o_ram_addr,
  output logic                   o_ram_read,
  input  logic [NB_ADC-1:0]      i_ram_value,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready
);

  localparam int COL_W = (PIXEL_N_COLS > 1) ? $clog2(PIXEL_N_COLS) : 1;
  localparam int ROW_W = (PIXEL_N_ROWS > 1) ? $clog2(PIXEL_N_ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_SEND_HI,
    S_SEND_LO,
    S_DONE
`ifdef READOUT_HEADER_EN
    ,
    S_HDR_0,
    S_HDR_1
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [NB_ADC-1:0] pix_q, pix_d;

  logic [15:0]       pix_ext;
  logic              last_col;
  logic              last_row;

  // Zero-extend the pixel to 16 bits so the high byte carries the top
  // NB_ADC-8 bits with leading zeros.
  assign pix_ext  = 16'(pix_q);
  assign last_col = (col_q == COL_W'(PIXEL_N_COLS - 1));
  assign last_row = (row_q == ROW_W'(PIXEL_N_ROWS - 1));

  // Row-major RAM address from the scan counters.
  assign o_ram_addr = NB_MEM_ADDR'(row_q) * NB_MEM_ADDR'(PIXEL_N_COLS)
                    + NB_MEM_ADDR'(col_q);

  // State, scan counters and captured pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
    end
  end

  // Next-state, counter updates and Moore outputs.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pix_d      = pix_q;
    o_busy     = (state_q != S_IDLE);
    o_done     = 1'b0;
    o_ram_read = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
`ifdef READOUT_HEADER_EN
          state_d = S_HDR_0;
`else
          state_d = S_RD_ADDR;
`endif
        end
      end
`ifdef READOUT_HEADER_EN
      S_HDR_0: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'hA5;
        if (i_tx_ready) state_d = S_HDR_1;
      end
      S_HDR_1: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h5A;
        if (i_tx_ready) state_d = S_RD_ADDR;
      end
`endif
      S_RD_ADDR: begin
        o_ram_read = 1'b1;
        state_d    = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        pix_d   = i_ram_value;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        o_tx_valid = 1'b1;
        o_tx_data  = pix_ext[15:8];
        if (i_tx_ready) state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        o_tx_valid = 1'b1;
        o_tx_data  = pix_ext[7:0];
        if (i_tx_ready) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          state_d = (last_row && last_col) ? S_DONE : S_RD_ADDR;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_readout_fsm.sv
// tb_readout_fsm: scoreboard bench for readout_fsm. Stimulus pushes the
// expected byte stream into a queue; a monitor pops on every transfer.
module tb_readout_fsm;

  localparam int COLS = 24;
  localparam int ROWS = 24;
  localparam int NPIX = COLS * ROWS;
`ifdef READOUT_HEADER_EN
  localparam int FRAME_BYTES = 2 * NPIX + 2;
`else
  localparam int FRAME_BYTES = 2 * NPIX;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic [9:0]  o_ram_addr;
  logic        o_ram_read;
  logic [11:0] i_ram_value;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  bit bp_en = 1'b0;
  logic [7:0] exp_q[$];

  readout_fsm #(
    .PIXEL_N_COLS(COLS),
    .PIXEL_N_ROWS(ROWS),
    .NB_ADC(12),
    .NB_MEM_ADDR(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_ram_addr(o_ram_addr),
    .o_ram_read(o_ram_read),
    .i_ram_value(i_ram_value),
    .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[a] = a & 12'hFFF, one cycle read latency.
  always @(posedge clk) begin
    if (o_ram_read) i_ram_value <= {2'b00, o_ram_addr} & 12'hFFF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    logic [15:0] v;
`ifdef READOUT_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
`endif
    for (int a = 0; a < NPIX; a++) begin
      v = 16'(a) & 16'h0FFF;
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no o_done expected o_done within %0d cycles", budget);
    end
  endtask

  // Ready driver: always ready, or ~50% random when backpressure is on.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on transfer, hold-stability check, o_done count.
  initial begin
    bit hold_prev;
    logic [7:0] data_prev;
    logic [7:0] e;
    hold_prev = 1'b0;
    data_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", o_tx_valid, 1);
          check("hold_data", o_tx_data, data_prev);
        end
        if (o_done) done_cnt++;
        if (o_tx_valid && i_tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h expected no byte", o_tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", o_tx_data, e);
          end
          xfer_cnt++;
        end
        hold_prev = o_tx_valid && !i_tx_ready;
        data_prev = o_tx_data;
      end
    end
  end

  initial begin
    int x0;
    int d0;
    int n;

    // Reset state
    rst = 1'b1;
    i_start = 1'b0;
    tick(3);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_read", o_ram_read, 0);
    check("rst_valid", o_tx_valid, 0);
    check("rst_addr", o_ram_addr, 0);
    check("rst_data", o_tx_data, 0);
    rst = 1'b0;
    tick(2);

    // Full frame, sink always ready, with start latency
    push_frame();
    x0 = xfer_cnt;
    d0 = done_cnt;
    pulse_start();
`ifdef READOUT_HEADER_EN
    check("lat_hdr_valid", o_tx_valid, 1);
    check("lat_hdr_data", o_tx_data, 8'hA5);
    check("lat_busy", o_busy, 1);
`else
    check("lat_k1_read", o_ram_read, 1);
    check("lat_k1_addr", o_ram_addr, 0);
    check("lat_k1_valid", o_tx_valid, 0);
    check("lat_busy", o_busy, 1);
    tick(1);
    check("lat_k2_valid", o_tx_valid, 0);
    check("lat_k2_read", o_ram_read, 0);
    tick(1);
    check("lat_k3_valid", o_tx_valid, 1);
    check("lat_k3_data", o_tx_data, 0);
`endif
    wait_done(8000);
    tick(3);
    check("f1_done_once", done_cnt - d0, 1);
    check("f1_bytes", xfer_cnt - x0, FRAME_BYTES);
    check("f1_queue_empty", exp_q.size(), 0);
    check("f1_idle_busy", o_busy, 0);
    check("f1_idle_addr", o_ram_addr, 0);

    // Backpressure
    bp_en = 1'b1;
    push_frame();
    x0 = xfer_cnt;
    d0 = done_cnt;
    pulse_start();
    wait_done(20000);
    bp_en = 1'b0;
    tick(3);
    check("bp_done_once", done_cnt - d0, 1);
    check("bp_bytes", xfer_cnt - x0, FRAME_BYTES);
    check("bp_queue_empty", exp_q.size(), 0);

    // Starts during readout are ignored and not queued
    push_frame();
    x0 = xfer_cnt;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (done_cnt == d0 && n < 8000) begin
      i_start = ((n % 37) == 5);
      tick(1);
      n++;
    end
    i_start = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL ign_timeout: got no o_done expected o_done within 8000 cycles");
    end
    tick(5);
    check("ign_busy_after", o_busy, 0);
    check("ign_done_once", done_cnt - d0, 1);
    check("ign_bytes", xfer_cnt - x0, FRAME_BYTES);
    push_frame();
    pulse_start();
    wait_done(8000);
    tick(3);
    check("ign2_done", done_cnt - d0, 2);
    check("ign2_bytes", xfer_cnt - x0, 2 * FRAME_BYTES);
    check("ign2_queue_empty", exp_q.size(), 0);

    // Mid-frame reset after byte 100
    push_frame();
    x0 = xfer_cnt;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (xfer_cnt - x0 < 100 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    rst = 1'b1;
    tick(1);
    check("mr_valid", o_tx_valid, 0);
    check("mr_busy", o_busy, 0);
    check("mr_done", o_done, 0);
    check("mr_read", o_ram_read, 0);
    check("mr_addr", o_ram_addr, 0);
    check("mr_bytes", xfer_cnt - x0, 100);
    exp_q.delete();
    rst = 1'b0;
    tick(3);
    check("mr_no_done", done_cnt - d0, 0);
    push_frame();
    x0 = xfer_cnt;
    pulse_start();
    check("mr_restart_addr", o_ram_addr, 0);
    wait_done(8000);
    tick(3);
    check("mr2_done", done_cnt - d0, 1);
    check("mr2_bytes", xfer_cnt - x0, FRAME_BYTES);
    check("mr2_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
